// File: rtl/seven_bit_result_reader.sv
// Read-out end of the pushbutton-loaded seven-bit adder.
// Captures {carry, sum} as an 8-bit snapshot and shows it one nibble at a time
// on four LEDs, under control of four synchronised, debounced pushbuttons.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   PB1            raw button: capture {carry,sum}, show low nibble
//   PB2            raw button: show high nibble
//   PB3            raw button: show low nibble
//   PB4            raw button: clear snapshot
//   sum, carry     adder result, sampled only when a PB1 press is consumed
//   LED            displayed nibble (registered)
//   result_valid   snapshot held (registered)
//   nibble_sel     0 = low nibble shown, 1 = high nibble shown (registered)
module seven_bit_result_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic [6:0] sum,
  input  logic       carry,
  output logic [3:0] LED,
  output logic       result_valid,
  output logic       nibble_sel
);

  localparam int unsigned NB     = 4;
  localparam int unsigned SNAP_W = 8;
  localparam int unsigned LED_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button bit positions within the per-button vectors.
  localparam int unsigned B_CAP = 0;
  localparam int unsigned B_HI  = 1;
  localparam int unsigned B_LO  = 2;
  localparam int unsigned B_CLR = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_t;

  logic [NB-1:0]    raw_c;
  logic [NB-1:0]    sync1_q, sync1_d;
  logic [NB-1:0]    sync2_q, sync2_d;
  logic [NB-1:0]    level_q, level_d;
  logic [NB-1:0]    evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  state_t            state_q, state_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              valid_q, valid_d;
  logic              nsel_q, nsel_d;

  assign raw_c = {PB4, PB3, PB2, PB1};

  // Two-flop synchroniser per button.
  always_comb begin
    sync1_d = raw_c;
    sync2_d = sync1_q;
  end

  // Debounce: count consecutive disagreeing samples; the level follows the
  // sample once DEBOUNCE_CYCLES of them have been seen. A rising level yields
  // a registered one-cycle press event.
  always_comb begin
    level_d = level_q;
    evt_d   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      evt_d[i] = level_d[i] & ~level_q[i];
    end
  end

  // Input path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      evt_q   <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      evt_q   <= evt_d;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Display FSM: only the highest-priority event of a cycle acts
  // (clear > capture > high > low); lower ones are dropped.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    led_d   = led_q;
    valid_d = valid_q;
    nsel_d  = nsel_q;
    if (evt_q[B_CLR]) begin
      state_d = EMPTY;
      snap_d  = '0;
      led_d   = '0;
      valid_d = 1'b0;
      nsel_d  = 1'b0;
    end else if (evt_q[B_CAP]) begin
      state_d = SHOW_LO;
      snap_d  = {carry, sum};
      led_d   = sum[3:0];
      valid_d = 1'b1;
      nsel_d  = 1'b0;
    end else if (evt_q[B_HI]) begin
      if (state_q != EMPTY) begin
        state_d = SHOW_HI;
        led_d   = snap_q[7:4];
        nsel_d  = 1'b1;
      end
    end else if (evt_q[B_LO]) begin
      if (state_q != EMPTY) begin
        state_d = SHOW_LO;
        led_d   = snap_q[3:0];
        nsel_d  = 1'b0;
      end
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      snap_q  <= '0;
      led_q   <= '0;
      valid_q <= 1'b0;
      nsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      led_q   <= led_d;
      valid_q <= valid_d;
      nsel_q  <= nsel_d;
    end
  end

  assign LED          = led_q;
  assign result_valid = valid_q;
  assign nibble_sel   = nsel_q;

endmodule

// File: tb/tb_seven_bit_result_reader.sv
// Self-checking bench for seven_bit_result_reader (DEBOUNCE_CYCLES = 4).
// Reference model: a button's debounced level flips when the last
// DEBOUNCE_CYCLES synchronised samples (raw value two edges earlier) all
// disagree with it; a rising level is acted on by the FSM one edge later.
module tb_seven_bit_result_reader;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pb;
  logic [6:0] sum;
  logic       carry;
  logic [3:0] LED;
  logic       result_valid;
  logic       nibble_sel;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] raw_hist[$];
  logic [3:0] m_level;
  logic [3:0] m_evt;
  int         m_state;   // 0 empty, 1 low nibble shown, 2 high nibble shown
  logic [7:0] m_snap;

  seven_bit_result_reader #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PB1          (pb[0]),
    .PB2          (pb[1]),
    .PB3          (pb[2]),
    .PB4          (pb[3]),
    .sum          (sum),
    .carry        (carry),
    .LED          (LED),
    .result_valid (result_valid),
    .nibble_sel   (nibble_sel)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    raw_hist.delete();
    m_level = '0;
    m_evt   = '0;
    m_state = 0;
    m_snap  = '0;
  endfunction

  function automatic void model_step();
    logic [3:0] nevt;
    bit         all_diff;
    int         idx;
    logic       smp;
    nevt = '0;
    if (m_evt[3]) begin
      m_state = 0;
      m_snap  = '0;
    end else if (m_evt[0]) begin
      m_state = 1;
      m_snap  = {carry, sum};
    end else if (m_evt[1]) begin
      if (m_state != 0) m_state = 2;
    end else if (m_evt[2]) begin
      if (m_state != 0) m_state = 1;
    end
    raw_hist.push_back(pb);
    if (raw_hist.size() > int'(DB) + 2) void'(raw_hist.pop_front());
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < int'(DB); j++) begin
        idx = raw_hist.size() - 3 - j;
        smp = (idx >= 0) ? raw_hist[idx][b] : 1'b0;
        if (smp == m_level[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_level[b] = ~m_level[b];
        if (m_level[b]) nevt[b] = 1'b1;
      end
    end
    m_evt = nevt;
  endfunction

  function automatic logic [5:0] exp_out();
    logic [3:0] led;
    case (m_state)
      0:       led = 4'h0;
      1:       led = m_snap[3:0];
      default: led = m_snap[7:4];
    endcase
    return {led, 1'(m_state != 0), 1'(m_state == 2)};
  endfunction

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  // Hold a button pattern for n cycles; report how many cycles disagreed
  // with the model and the first disagreeing pair.
  task automatic drive(input logic [3:0] p, input int n, output int bad,
                       output logic [5:0] got, output logic [5:0] exp);
    bad = 0;
    got = '0;
    exp = '0;
    pb  = p;
    repeat (n) begin
      tick();
      if ({LED, result_valid, nibble_sel} !== exp_out()) begin
        if (bad == 0) begin
          got = {LED, result_valid, nibble_sel};
          exp = exp_out();
        end
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    logic [5:0] g, e;
    pb = '0; sum = 7'h7F; carry = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if ({LED, result_valid, nibble_sel} !== 6'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, {LED, result_valid, nibble_sel}, 6'b0);
      end
    end
    drive(4'b0001, 10, bad, g, e);
    drive(4'b0000, 3, bad, g, e);
    checks++;
    if ({LED, result_valid} !== {4'hF, 1'b1}) begin
      failures++;
      $display("FAIL reset_precapture got=%b exp=%b", {LED, result_valid}, {4'hF, 1'b1});
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0);
    end
    tick();
    rst_n = 1'b1;
    drive(4'b0000, 10, bad, g, e);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_release bad=%0d got=%b exp=%b", bad, g, e);
    end
  endtask

  task automatic test_capture();
    int bad;
    logic [5:0] g, e;
    sum = 7'b1010101; carry = 1'b1;
    pb = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) begin
        checks++;
        if ({LED, result_valid} !== 5'b0) begin
          failures++;
          $display("FAIL capture_early got=%b exp=%b", {LED, result_valid}, 5'b0);
        end
      end
      if (k == 7) begin
        checks++;
        if ({LED, result_valid, nibble_sel} !== 6'b0101_1_0) begin
          failures++;
          $display("FAIL capture_latency got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0101_1_0);
        end
      end
    end
    drive(4'b0000, 10, bad, g, e);
    sum = 7'h00; carry = 1'b0;
    drive(4'b0010, 10, bad, g, e);
    drive(4'b0000, 10, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b1101_1_1) begin
      failures++;
      $display("FAIL show_high got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b1101_1_1);
    end
    drive(4'b0100, 10, bad, g, e);
    drive(4'b0000, 10, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0101_1_0) begin
      failures++;
      $display("FAIL show_low got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0101_1_0);
    end
  endtask

  task automatic test_debounce();
    int bad, tot;
    logic [5:0] g, e;
    tot = 0;
    for (int r = 0; r < 2; r++) begin
      drive(4'b0010, 2, bad, g, e); tot += bad;
      drive(4'b0000, 2, bad, g, e); tot += bad;
    end
    drive(4'b0000, 20, bad, g, e); tot += bad;
    checks++;
    if (tot != 0 || {LED, result_valid, nibble_sel} !== 6'b0101_1_0) begin
      failures++;
      $display("FAIL glitch_ignored bad=%0d got=%b exp=%b", tot, {LED, result_valid, nibble_sel}, 6'b0101_1_0);
    end
    sum = 7'h0A; carry = 1'b0;
    drive(4'b0001, 20, bad, g, e);
    sum = 7'h55; carry = 1'b1;
    drive(4'b0001, 20, bad, g, e);
    drive(4'b0000, 10, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b1010_1_0) begin
      failures++;
      $display("FAIL held_single_capture got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b1010_1_0);
    end
  endtask

  task automatic test_empty_ignore();
    int bad;
    logic [5:0] g, e;
    #2 rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    drive(4'b0010, 8, bad, g, e);
    drive(4'b0000, 8, bad, g, e);
    drive(4'b0100, 8, bad, g, e);
    drive(4'b0000, 8, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0) begin
      failures++;
      $display("FAIL empty_ignore got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0);
    end
  endtask

  task automatic test_priority();
    int bad;
    logic [5:0] g, e;
    sum = 7'h3C; carry = 1'b0;
    drive(4'b0001, 8, bad, g, e);
    drive(4'b0000, 8, bad, g, e);
    drive(4'b0010, 8, bad, g, e);
    drive(4'b0000, 8, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0011_1_1) begin
      failures++;
      $display("FAIL prio_setup got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0011_1_1);
    end
    drive(4'b1001, 8, bad, g, e);
    drive(4'b0000, 8, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0) begin
      failures++;
      $display("FAIL prio_clear_over_capture got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0);
    end
    sum = 7'h12; carry = 1'b0;
    drive(4'b0011, 8, bad, g, e);
    drive(4'b0000, 8, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0010_1_0) begin
      failures++;
      $display("FAIL prio_capture_over_high got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0010_1_0);
    end
    drive(4'b0010, 8, bad, g, e);
    drive(4'b0000, 8, bad, g, e);
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0001_1_1) begin
      failures++;
      $display("FAIL prio_snap_high got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0001_1_1);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int bad;
    logic [5:0] g, e;
    sum = 7'h29; carry = 1'b1;
    pb = 4'b0001;
    tick(); tick(); tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({LED, result_valid, nibble_sel} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_clear got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b0);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (k < 7 && {LED, result_valid} !== 5'b0) begin
        failures++;
        $display("FAIL midreset_early cyc=%0d got=%b exp=%b", k, {LED, result_valid}, 5'b0);
      end else if (k == 7 && {LED, result_valid, nibble_sel} !== 6'b1001_1_0) begin
        failures++;
        $display("FAIL midreset_capture got=%b exp=%b", {LED, result_valid, nibble_sel}, 6'b1001_1_0);
      end
    end
    drive(4'b0000, 10, bad, g, e);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_trace bad=%0d got=%b exp=%b", bad, g, e);
    end
  endtask

  task automatic test_random();
    int bad;
    logic [5:0] g, e;
    logic [3:0] m;
    for (int s = 0; s < 80; s++) begin
      sum   = 7'($urandom);
      carry = 1'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      drive(m, $urandom_range(1, 12), bad, g, e);
      sum = 7'($urandom);
      drive(4'b0000, $urandom_range(1, 10), bad, g, e);
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL random seg=%0d mask=%b bad=%0d got=%b exp=%b", s, m, bad, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_debounce();
    test_empty_ignore();
    test_priority();
    test_reset_mid_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_bit_result_reader.md
Name: seven_bit_result_reader

Overview:
- Read-out end of the pushbutton-loaded seven-bit adder.
- Captures the adder's 7-bit sum and carry as one 8-bit snapshot. The snapshot is presented nibble-by-nibble on four board LEDs, selected by the same four pushbuttons.
- Raw board buttons are synchronised and debounced. The block sits between the adder outputs and the LED pins.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required before a button's debounced level changes (minimum 2)
CNT_W, 5, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
PB1  input  1  raw button: capture {carry,sum}, show low nibble
PB2  input  1  raw button: show high nibble
PB3  input  1  raw button: show low nibble
PB4  input  1  raw button: clear snapshot
sum  input  7  adder sum
carry  input  1  adder carry-out
LED  output  4  displayed nibble
result_valid  output  1  snapshot held
nibble_sel  output  1  0 = low nibble shown, 1 = high nibble shown

Behaviour:
- Reset (rst_n low, asynchronous): LED=0, result_valid=0, nibble_sel=0, snapshot=8'h00, state EMPTY. All synchroniser flops, debounced levels and counters are cleared to 0. Reset mid-debounce or mid-display discards everything; no event fires on reset release.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce: the counter increments while the synchronised sample differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sample and the counter clears.
  - Press event: 1-cycle pulse on a debounced 0->1 transition. Release generates no event. A held button generates exactly one event. Glitches shorter than DEBOUNCE_CYCLES cycles generate no event.
- Latency:
  - Raw edge to event: 2 + DEBOUNCE_CYCLES cycles.
  - Event to outputs updated: 1 cycle (registered).
- Snapshot: snap[7:0] = {carry, sum[6:0]}, sampled on the clock edge that consumes the PB1 event. sum/carry are sampled only at that edge.
- FSM states: EMPTY, SHOW_LO, SHOW_HI.
  - Any state, PB4 -> EMPTY: snap=0, LED=0, result_valid=0, nibble_sel=0.
  - Any state, PB1 -> SHOW_LO: recapture snap, LED=new snap[3:0], result_valid=1, nibble_sel=0.
  - SHOW_LO/SHOW_HI, PB2 -> SHOW_HI: LED=snap[7:4], nibble_sel=1.
  - SHOW_LO/SHOW_HI, PB3 -> SHOW_LO: LED=snap[3:0], nibble_sel=0.
  - EMPTY, PB2 or PB3: ignored; outputs unchanged.
  - No event: hold state and outputs.
- Simultaneous events in one cycle: priority PB4 > PB1 > PB2 > PB3. Only the highest-priority event acts; the others are dropped, not queued.
- Outputs are derived purely from registers; there is no combinational path from any input to any output.
- result_valid=1 exactly in SHOW_LO/SHOW_HI. nibble_sel=1 exactly in SHOW_HI.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset check: rst_n=0 asserted mid-cycle -> LED=0000, result_valid=0, nibble_sel=0 immediately. Release, no buttons -> outputs unchanged for 50 cycles.
- Capture and read-out: sum=7'b1010101, carry=1, press PB1 (held 10 cycles) -> exactly 7 cycles after the raw edge LED=0101, result_valid=1. Change sum to 0, press PB2 -> LED=1101, nibble_sel=1. Press PB3 -> LED=0101.
- Debounce: PB2 toggled 1-0-1-0 every 2 cycles, then low -> no change. PB1 held 40 cycles -> single capture only; sum changed during the hold is not recaptured.
- Empty-state ignore: after reset, press PB2 then PB3 -> LED=0000, result_valid=0, state EMPTY.
- Priority: in SHOW_HI with snap=8'h3C, PB1 and PB4 rise in the same cycle -> EMPTY, LED=0000. Repeat with PB1+PB2, sum=7'h12, carry=0 -> SHOW_LO, LED=0010, snap=8'h12.
- Reset mid-debounce: PB1 high for 3 cycles, rst_n pulsed low, PB1 held high afterwards -> no capture until a full 2+4 cycles elapse after reset release. Then capture occurs, with LED updating 1 cycle later.
